// File: rtl/halfdup_pkg.sv
// halfdup_pkg: shared FSM states and default constants for the half-duplex bus responder.
package halfdup_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, TURN_IN, DRIVE, TURN_OUT} state_t;
    localparam int WIDTH_DEF = 10;
    localparam logic [WIDTH_DEF-1:0] ERR_WORD_DEF = '1;
endpackage

// File: rtl/halfdup_wr_fifo.sv
// halfdup_wr_fifo: write-word FIFO; pointers carry one extra wrap bit so full and empty differ.
module halfdup_wr_fifo
    import halfdup_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wptr, rptr;
    assign empty = wptr == rptr;
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = mem[rptr[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push && !full) wptr <= wptr + (AW+1)'(1);
            if (pop && !empty) rptr <= rptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) mem[wptr[AW-1:0]] <= data;
    end
endmodule

// File: rtl/halfdup_bus_responder.sv
// halfdup_bus_responder: responder end of a half-duplex bus; buffers writes, fetches and drives reads
// with one released turnaround cycle on each side of the drive cycle.
module halfdup_bus_responder
    import halfdup_pkg::*;
#(
    parameter int               WIDTH    = WIDTH_DEF,
    parameter int               DEPTH    = 4,
    parameter int               TIMEOUT  = 15,
    parameter logic [WIDTH-1:0] ERR_WORD = '1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    inout  wire  [WIDTH-1:0] io_bus,
    input  logic             i_req,
    input  logic             i_req_wr,
    output logic             o_ready,
    output logic             o_rd_strobe,
    output logic             o_rd_err,
    output logic             o_wr_valid,
    output logic [WIDTH-1:0] o_wr_data,
    input  logic             i_wr_ready,
    output logic             o_rd_req,
    input  logic             i_rd_valid,
    input  logic [WIDTH-1:0] i_rd_data,
    output logic             o_overflow
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] word;
    logic err, full, empty, timeout;
    assign timeout = cnt == CW'(TIMEOUT);
    assign io_bus = o_rd_strobe ? word : 'z;
    assign o_wr_valid = !empty;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) state <= IDLE;
        else state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:     state_nx = (i_req && !i_req_wr && o_ready) ? FETCH : IDLE;
            FETCH:    state_nx = (i_rd_valid || timeout) ? TURN_IN : FETCH;
            TURN_IN:  state_nx = DRIVE;
            DRIVE:    state_nx = TURN_OUT;
            TURN_OUT: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end
    always_comb begin
        o_ready     = (state == IDLE) && !full;
        o_rd_req    = state == FETCH;
        o_rd_strobe = state == DRIVE;
        o_rd_err    = (state == DRIVE) && err;
    end
    // Data beats the timeout when both land in the same FETCH cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt        <= '0;
            word       <= '0;
            err        <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            if (state == FETCH) begin
                word <= i_rd_valid ? i_rd_data : (timeout ? ERR_WORD : word);
                err  <= i_rd_valid ? 1'b0 : (timeout ? 1'b1 : err);
                if (!timeout) cnt <= cnt + CW'(1);
            end else if (state == TURN_OUT) begin
                cnt <= '0;
            end
            if (i_req && i_req_wr && full) o_overflow <= 1'b1;
        end
    end
    halfdup_wr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (i_req && i_req_wr && o_ready),
        .data  (io_bus),
        .pop   (o_wr_valid && i_wr_ready),
        .full  (full),
        .empty (empty),
        .head  (o_wr_data)
    );
endmodule

// File: tb/tb_halfdup_bus_responder.sv
// tb_halfdup_bus_responder: directed stimulus against a queue/cycle-count model plus literal pins.
module tb_halfdup_bus_responder;
    localparam int W = 10, D = 4, T = 15;
    logic clk = 0, rst_n = 0, req = 0, req_wr = 0, wr_ready = 0, rd_valid = 0, tb_drv = 0;
    logic [W-1:0] rd_data = '0, tb_bus = '0, wr_data;
    logic ready, rd_strobe, rd_err, wr_valid, rd_req, overflow;
    wire  [W-1:0] io_bus;
    int vectors = 0, errors = 0;
    assign io_bus = tb_drv ? tb_bus : 'z;
    always #5 clk = ~clk;

    halfdup_bus_responder #(.WIDTH(W), .DEPTH(D), .TIMEOUT(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .io_bus(io_bus), .i_req(req), .i_req_wr(req_wr),
        .o_ready(ready), .o_rd_strobe(rd_strobe), .o_rd_err(rd_err), .o_wr_valid(wr_valid),
        .o_wr_data(wr_data), .i_wr_ready(wr_ready), .o_rd_req(rd_req), .i_rd_valid(rd_valid),
        .i_rd_data(rd_data), .o_overflow(overflow)
    );

    task automatic chk_bit(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask
    task automatic chk_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask
    // An undriven bus resolves to z (4-state) or 0 (2-state); every driven test word is non-zero.
    task automatic chk_released(input string name);
        vectors++;
        if (!(io_bus === 'z || io_bus === '0)) begin
            errors++;
            $display("FAIL %s: got %h expected released bus at %0t", name, io_bus, $time);
        end
    endtask

    // Model: FIFO as a queue; a read is "fetching" then counts cycles since the fetch ended.
    logic [W-1:0] mq[$];
    logic [W-1:0] m_word = '0;
    bit m_live = 0, m_busy = 0, m_fetch = 0, m_err = 0, m_ovf = 0;
    bit m_rdy, m_pop, m_push, m_drv;
    int m_fcnt = 0, m_after = 0;
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_live = 1; m_busy = 0; m_fetch = 0; m_ovf = 0; m_fcnt = 0; m_after = 0;
        end else if (m_live) begin
            m_rdy  = !m_busy && mq.size() < D;
            m_pop  = mq.size() > 0 && wr_ready;
            m_push = req && req_wr && m_rdy;
            if (req && req_wr && mq.size() == D) m_ovf = 1;
            if (m_fetch) begin
                if (rd_valid || m_fcnt == T) begin
                    m_word = rd_valid ? rd_data : '1;
                    m_err = !rd_valid;
                    m_fetch = 0;
                    m_after = 1;
                end else m_fcnt++;
            end else if (m_busy) begin
                m_after++;
                if (m_after == 4) m_busy = 0;
            end else if (req && !req_wr && m_rdy) begin
                m_busy = 1; m_fetch = 1; m_fcnt = 0;
            end
            if (m_pop) void'(mq.pop_front());
            if (m_push) mq.push_back(tb_bus);
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            m_drv = m_busy && !m_fetch && m_after == 2;
            chk_bit("m_ready", ready, !m_busy && mq.size() < D);
            chk_bit("m_rd_req", rd_req, m_fetch);
            chk_bit("m_rd_strobe", rd_strobe, m_drv);
            chk_bit("m_rd_err", rd_err, m_drv && m_err);
            chk_bit("m_wr_valid", wr_valid, mq.size() > 0);
            chk_bit("m_overflow", overflow, m_ovf);
            if (mq.size() > 0) chk_word("m_wr_data", wr_data, mq[0]);
            if (m_drv) chk_word("m_bus", io_bus, m_word);
            else if (!tb_drv) chk_released("m_bus_released");
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [W-1:0] v);
        req = 1; req_wr = 1; tb_drv = 1; tb_bus = v;
        tick();
        req = 0; req_wr = 0; tb_drv = 0;
    endtask
    task automatic rd_start();
        req = 1; req_wr = 0;
        tick();
        req = 0;
    endtask

    initial begin
        tick(); tick();
        chk_bit("rst_ready", ready, 1);
        chk_bit("rst_strobe", rd_strobe, 0);
        chk_bit("rst_err", rd_err, 0);
        chk_bit("rst_wr_valid", wr_valid, 0);
        chk_bit("rst_rd_req", rd_req, 0);
        chk_bit("rst_overflow", overflow, 0);
        chk_released("rst_bus");
        rst_n = 1;
        tick();
        for (int i = 1; i <= 4; i++) wr(W'(i));
        chk_bit("full_ready", ready, 0);
        chk_word("head_first", wr_data, 10'h001);
        wr(10'h005);
        chk_bit("ovf_set", overflow, 1);
        wr_ready = 1;
        for (int i = 1; i <= 4; i++) begin
            chk_word("pop_order", wr_data, W'(i));
            tick();
        end
        chk_bit("drained", wr_valid, 0);
        wr_ready = 0;
        rd_start();
        chk_bit("fetch_req", rd_req, 1);
        tick(); tick();
        rd_valid = 1; rd_data = 10'h2A5;
        tick();
        rd_valid = 0;
        chk_bit("turnin_req", rd_req, 0);
        chk_bit("turnin_strobe", rd_strobe, 0);
        chk_released("turnin_bus");
        tick();
        chk_word("drive_data", io_bus, 10'h2A5);
        chk_bit("drive_strobe", rd_strobe, 1);
        chk_bit("drive_err", rd_err, 0);
        tick();
        chk_released("turnout_bus");
        chk_bit("turnout_ready", ready, 0);
        tick();
        chk_bit("read_idle", ready, 1);
        rd_start();
        for (int i = 0; i < T + 2; i++) begin
            chk_bit("to_wait_strobe", rd_strobe, 0);
            tick();
        end
        chk_word("to_data", io_bus, 10'h3FF);
        chk_bit("to_strobe", rd_strobe, 1);
        chk_bit("to_err", rd_err, 1);
        tick(); tick();
        rd_start();
        for (int i = 0; i < T; i++) tick();
        rd_valid = 1; rd_data = 10'h0AA;
        tick();
        rd_valid = 0;
        tick();
        chk_word("edge_data", io_bus, 10'h0AA);
        chk_bit("edge_err", rd_err, 0);
        tick(); tick();
        rd_valid = 1; rd_data = 10'h155;
        rd_start();
        tick();
        rd_valid = 0;
        tick();
        chk_word("fast_data", io_bus, 10'h155);
        chk_bit("fast_strobe", rd_strobe, 1);
        tick(); tick();
        chk_bit("fast_idle", ready, 1);
        rst_n = 0; tick(); rst_n = 1;
        chk_bit("rst_clr_ovf", overflow, 0);
        for (int i = 5; i <= 8; i++) wr(W'(i));
        req = 1; req_wr = 1; tb_drv = 1; tb_bus = 10'h009; wr_ready = 1;
        tick();
        req = 0; req_wr = 0; tb_drv = 0;
        chk_word("pp_head", wr_data, 10'h006);
        chk_bit("pp_ovf", overflow, 1);
        chk_bit("pp_ready", ready, 1);
        for (int i = 6; i <= 8; i++) begin
            chk_word("pp_drain", wr_data, W'(i));
            tick();
        end
        chk_bit("pp_empty", wr_valid, 0);
        wr_ready = 0;
        wr(10'h011);
        rd_start();
        tick();
        rst_n = 0;
        tick();
        chk_bit("mid_rst_ready", ready, 1);
        chk_bit("mid_rst_rd_req", rd_req, 0);
        chk_bit("mid_rst_wr_valid", wr_valid, 0);
        chk_bit("mid_rst_ovf", overflow, 0);
        chk_released("mid_rst_bus");
        rst_n = 1;
        tick(); tick(); tick();
        chk_bit("post_rst_strobe", rd_strobe, 0);
        chk_bit("post_rst_ready", ready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
